// File: rtl/id_pkg.sv
// ============================================================================
// id_pkg : shared types and constants for the student-ID sequencer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package id_pkg;

    localparam int ID_LEN = 8;

    localparam logic [3:0] ID_SEQ [0:ID_LEN-1] =
        '{4'hA, 4'hB, 4'h1, 4'h5, 4'h7, 4'h0, 4'hC, 4'h4};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/id_tick_div.sv
// ============================================================================
// id_tick_div : prescaler producing one tick every DIV enabled cycles
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module id_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [7:0] C_LAST = 8'(DIV - 1);

    logic [7:0] r_cnt;

    assign tick = en && (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= 8'd0;
        end else if (en) begin
            r_cnt <= tick ? 8'd0 : r_cnt + 8'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/id_seq_ctrl.sv
// ============================================================================
// id_seq_ctrl : run/pause/step/abort sequencer for the 8-digit ID stream
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module id_seq_ctrl #(
    parameter int DIV   = 4,
    parameter int LOOPS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic       mode_loop,
    output logic [3:0] id,
    output logic [2:0] pos,
    output logic       id_valid,
    output logic       wrap,
    output logic       busy,
    output logic       done
);

    import id_pkg::*;

    localparam logic [3:0] C_LOOPS = 4'(LOOPS);

    state_t     r_state, w_state_n;
    logic [2:0] r_pos, w_pos_n;
    logic [3:0] r_loop, w_loop_n;
    logic       w_wrap_n;
    logic       w_clr;
    logic       w_adv;
    logic       w_tick;
    logic       w_active_n;

    id_tick_div #(
        .DIV (DIV)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (r_state == RUN),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    always_comb begin
        w_state_n = r_state;
        w_pos_n   = r_pos;
        w_loop_n  = r_loop;
        w_wrap_n  = 1'b0;
        w_clr     = 1'b0;
        w_adv     = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                w_pos_n = 3'd0;
                if (start) begin
                    w_state_n = RUN;
                    w_loop_n  = 4'd0;
                    w_clr     = 1'b1;
                end
            end
            RUN: begin
                // A tick on the same edge as stop still advances.
                if (stop) w_state_n = PAUSE;
                w_adv = w_tick;
            end
            PAUSE: begin
                if (stop) begin
                    w_state_n = IDLE;
                    w_pos_n   = 3'd0;
                    w_loop_n  = 4'd0;
                    w_clr     = 1'b1;
                end else if (start) begin
                    w_state_n = RUN;
                end else if (step) begin
                    w_adv = 1'b1;
                end
            end
            default: w_state_n = IDLE;
        endcase

        if (w_adv) begin
            if (r_pos == 3'd7) begin
                w_pos_n  = 3'd0;
                w_wrap_n = 1'b1;
                w_loop_n = (r_loop == 4'hF) ? r_loop : r_loop + 4'd1;
                if (!mode_loop && (w_loop_n == C_LOOPS)) w_state_n = DONE;
            end else begin
                w_pos_n = r_pos + 3'd1;
            end
        end
    end

    assign w_active_n = (w_state_n == RUN) || (w_state_n == PAUSE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_pos    <= 3'd0;
            r_loop   <= 4'd0;
            id       <= ID_SEQ[0];
            id_valid <= 1'b0;
            wrap     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_pos    <= w_pos_n;
            r_loop   <= w_loop_n;
            id       <= ID_SEQ[w_pos_n];
            id_valid <= w_active_n;
            wrap     <= w_wrap_n;
            busy     <= w_active_n;
            done     <= (w_state_n == DONE);
        end
    end

    assign pos = r_pos;

endmodule

`default_nettype wire

// File: tb/tb_id_seq_ctrl.sv
// ============================================================================
// tb_id_seq_ctrl : directed bench for id_seq_ctrl (DIV=4 and DIV=1 instances)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_id_seq_ctrl;

    logic       clk;
    logic       reset, start, stop, step, mode_loop;
    logic [3:0] id,  id1;
    logic [2:0] pos, pos1;
    logic       id_valid, wrap, busy, done;
    logic       id_valid1, wrap1, busy1, done1;

    int total = 0;
    int bad   = 0;

    logic [3:0] seq [8] = '{4'hA, 4'hB, 4'h1, 4'h5, 4'h7, 4'h0, 4'hC, 4'h4};
    logic [3:0] step_exp [5] = '{4'h7, 4'h0, 4'hC, 4'h4, 4'hA};

    id_seq_ctrl #(.DIV(4), .LOOPS(2)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
        .mode_loop(mode_loop), .id(id), .pos(pos), .id_valid(id_valid),
        .wrap(wrap), .busy(busy), .done(done)
    );

    id_seq_ctrl #(.DIV(1), .LOOPS(2)) dut1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
        .mode_loop(mode_loop), .id(id1), .pos(pos1), .id_valid(id_valid1),
        .wrap(wrap1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called right after the start edge: 16 advances, one every 4 cycles.
    task automatic run_oneshot(input string tag);
        int wc;
        wc = 0;
        for (int k = 1; k <= 16; k++) begin
            repeat (3) begin
                cyc(1);
                wc += int'(wrap);
                chk({tag, "_hold_id"}, id, seq[(k - 1) % 8]);
            end
            cyc(1);
            wc += int'(wrap);
            chk({tag, "_adv_id"}, id, seq[k % 8]);
            chk({tag, "_done"}, done, (k == 16));
            chk({tag, "_busy"}, busy, (k != 16));
        end
        chk({tag, "_wrap_count"}, wc, 2);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; mode_loop = 1'b0;
        cyc(2);
        reset = 1'b0;
        chk("rst_id", id, 4'hA);
        chk("rst_pos", pos, 3'd0);
        chk("rst_valid", id_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        step = 1'b1; stop = 1'b1;
        cyc(1);
        step = 1'b0; stop = 1'b0;
        chk("idle_ignore_busy", busy, 1'b0);
        chk("idle_ignore_id", id, 4'hA);

        // One-shot, two passes
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t1_busy", busy, 1'b1);
        chk("t1_valid", id_valid, 1'b1);
        chk("t1_id0", id, 4'hA);
        run_oneshot("t1");
        cyc(1);
        chk("t1_post_wrap", wrap, 1'b0);
        chk("t1_post_done", done, 1'b1);
        chk("t1_post_id", id, 4'hA);
        chk("t1_post_valid", id_valid, 1'b0);

        // Restart from DONE
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t6_busy", busy, 1'b1);
        chk("t6_done", done, 1'b0);
        chk("t6_id0", id, 4'hA);
        run_oneshot("t6");

        // Pause at pos 3, step through wrap, resume
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(12);
        chk("t2_pos3", pos, 3'd3);
        chk("t2_id5", id, 4'h5);
        stop = 1'b1; cyc(1); stop = 1'b0;
        cyc(20);
        chk("t2_hold_id", id, 4'h5);
        chk("t2_hold_pos", pos, 3'd3);
        chk("t2_hold_busy", busy, 1'b1);
        chk("t2_hold_valid", id_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step = 1'b1; cyc(1);
            chk("t2_step_id", id, step_exp[i]);
            chk("t2_step_wrap", wrap, (i == 4));
        end
        step = 1'b0; cyc(1);
        chk("t2_after_wrap", wrap, 1'b0);
        chk("t2_after_done", done, 1'b0);
        chk("t2_after_busy", busy, 1'b1);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t2_resume0", id, 4'hA);
        cyc(2);
        chk("t2_resume2", id, 4'hA);
        cyc(1);
        chk("t2_resume3", id, 4'hB);

        // start+stop together in RUN, then abort
        start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
        chk("t4_pause_busy", busy, 1'b1);
        cyc(2);
        chk("t4_pause_id", id, 4'hB);
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("t4_abort_pos", pos, 3'd0);
        chk("t4_abort_id", id, 4'hA);
        chk("t4_abort_busy", busy, 1'b0);
        chk("t4_abort_valid", id_valid, 1'b0);

        // Reset mid-run at pos 6, with start in the same cycle
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(24);
        chk("t5_pos6", pos, 3'd6);
        chk("t5_idC", id, 4'hC);
        reset = 1'b1; start = 1'b1; cyc(1); reset = 1'b0; start = 1'b0;
        chk("t5_pos", pos, 3'd0);
        chk("t5_id", id, 4'hA);
        chk("t5_valid", id_valid, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_wrap", wrap, 1'b0);
        chk("t5_done", done, 1'b0);
        cyc(5);
        chk("t5_stay_idle", busy, 1'b0);

        // Loop mode; DIV=1 instance advances every cycle
        mode_loop = 1'b1;
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t3_start_id", id1, 4'hA);
        for (int c = 1; c <= 100; c++) begin
            cyc(1);
            chk("t3_id", id1, seq[c % 8]);
            chk("t3_wrap", wrap1, (c % 8 == 0));
            chk("t3_done", done1, 1'b0);
        end
        chk("t3_busy1", busy1, 1'b1);
        chk("t3_div4_done", done, 1'b0);
        chk("t3_div4_id", id, 4'hB);
        chk("t3_div4_busy", busy, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
